// File: rtl/dma_bus_if.sv
// dma_bus_if: HLD/HLDA-arbitrated word bus shared by the core, dataMemory, io1 and the DMA block mover.
interface dma_bus_if #(
   parameter int AW = 16,
   parameter int DW = 32
);
   logic          hld;
   logic          hlda;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   modport master (output hld, mem_addr, mem_rd, mem_wr, mem_wdata, input hlda, mem_rdata);
   modport slave  (input hld, mem_addr, mem_rd, mem_wr, mem_wdata, output hlda, mem_rdata);
endinterface

// File: rtl/dma_block_mover.sv
// dma_block_mover: copies COUNT words from SRC to DST over the shared bus, yielding every MAX_BURST words.
module dma_block_mover #(
   parameter int AW        = 16,
   parameter int DW        = 32,
   parameter int MAX_BURST = 8
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_addr,
   input  logic [AW-1:0] cfg_wdata,
   dma_bus_if.master     bus,
   output logic          busy,
   output logic          done,
   output logic          irq,
   output logic          err
);
   localparam int BW = $clog2(MAX_BURST + 1);
   typedef enum logic [2:0] {IDLE, REQ, RD, WR, YIELD, REL} state_t;
   state_t state, state_n;
   logic [AW-1:0] src, dst, count;
   logic [DW-1:0] buffer;
   logic [BW-1:0] burst, burst_nxt;
   logic ie, abort_q, ok;
   logic ctrl_wr, idle_wr, start, abort, clr, last, fin, zero_start;
   assign ctrl_wr    = cfg_we && cfg_addr == 2'd3;
   assign idle_wr    = cfg_we && state == IDLE;
   assign start      = idle_wr && cfg_addr == 2'd3 && cfg_wdata[0];
   assign zero_start = start && count == '0;
   assign abort      = abort_q || (ctrl_wr && cfg_wdata[3] && state != IDLE);
   assign clr        = ctrl_wr && cfg_wdata[2];
   assign last       = count == AW'(1);
   assign burst_nxt  = burst + 1'b1;
   // A tenure that reaches REL only reports completion if its last word went out cleanly.
   assign fin        = state == REL && !bus.hlda;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start && count != '0 ? REQ : IDLE;
         REQ:     state_n = abort ? REL : bus.hlda ? RD : REQ;
         RD:      state_n = bus.hlda ? WR : REL;
         WR:      state_n = !bus.hlda || last || abort ? REL :
                            burst_nxt == BW'(MAX_BURST) ? YIELD : RD;
         YIELD:   state_n = abort ? REL : !bus.hlda ? REQ : YIELD;
         REL:     state_n = bus.hlda ? REL : IDLE;
         default: state_n = IDLE;
      endcase
   end
   assign bus.hld       = state == REQ || state == RD || state == WR;
   assign bus.mem_rd    = state == RD;
   assign bus.mem_wr    = state == WR;
   assign bus.mem_addr  = state == RD ? src : state == WR ? dst : '0;
   assign bus.mem_wdata = state == WR ? buffer : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src     <= '0;
         dst     <= '0;
         count   <= '0;
         buffer  <= '0;
         burst   <= '0;
         ie      <= 1'b0;
         abort_q <= 1'b0;
         ok      <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         irq     <= 1'b0;
         err     <= 1'b0;
      end else begin
         if (idle_wr && cfg_addr == 2'd0) src   <= cfg_wdata;
         if (idle_wr && cfg_addr == 2'd1) dst   <= cfg_wdata;
         if (idle_wr && cfg_addr == 2'd2) count <= cfg_wdata;
         if (idle_wr && cfg_addr == 2'd3) ie    <= cfg_wdata[1];
         if (state == RD) buffer <= bus.mem_rdata;
         if (state == WR) begin
            src   <= src + 1'b1;
            dst   <= dst + 1'b1;
            count <= count - 1'b1;
            burst <= burst_nxt;
            ok    <= bus.hlda && last && !abort;
         end
         if (start) begin
            burst <= '0;
            ok    <= 1'b0;
         end
         if (state == YIELD) burst <= '0;
         abort_q <= state_n != IDLE && abort;
         busy    <= state_n != IDLE;
         done    <= zero_start || (fin && ok);
         irq     <= (zero_start && cfg_wdata[1]) || (fin && ok && ie) || (irq && !clr);
         err     <= ((state == RD || state == WR) && !bus.hlda) || (err && !clr);
      end
   end
endmodule

// File: tb/tb_dma_block_mover.sv
// tb_dma_block_mover: directed moves with a bus-strobe scoreboard, a simple HLD/HLDA arbiter and a word memory.
module tb_dma_block_mover;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = '0;
   logic [15:0] cfg_wdata = '0;
   logic        busy, done, irq, err;
   int errors = 0, checks = 0;
   int strobe_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, tenures = 0, grant_cnt = 0;
   logic kill = 1'b0, sb_on = 1'b1, hld_prev = 1'b0;
   logic [15:0] rd_q[$];
   logic [47:0] wr_q[$];
   logic [31:0] mem [0:65535];

   dma_bus_if #(.AW(16), .DW(32)) bus();
   dma_block_mover #(.AW(16), .DW(32), .MAX_BURST(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .bus(bus), .busy(busy), .done(done), .irq(irq), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [15:0] a);
      return {~a, a};
   endfunction

   assign bus.mem_rdata = mem[bus.mem_addr];
   always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;

   // Core side grants two cycles after hld rises and drops hlda as soon as hld falls.
   always @(negedge clk) begin
      grant_cnt = bus.hld ? grant_cnt + 1 : 0;
      bus.hlda = !kill && bus.hld && grant_cnt >= 2;
   end

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         logic [15:0] ea;
         logic [47:0] ew;
         if (bus.mem_rd && bus.mem_wr) chk("both_strobes", 1, 0);
         if (bus.mem_rd) begin
            rd_cnt++;
            if (sb_on) begin
               if (rd_q.size() == 0) chk("unexpected_rd", {32'h0, bus.mem_addr}, 48'hFFFF_FFFF_FFFF);
               else begin
                  ea = rd_q.pop_front();
                  chk("rd_addr", {32'h0, bus.mem_addr}, {32'h0, ea});
               end
            end
         end
         if (bus.mem_wr) begin
            wr_cnt++;
            if (sb_on) begin
               if (wr_q.size() == 0) chk("unexpected_wr", {bus.mem_addr, bus.mem_wdata}, 48'hFFFF_FFFF_FFFF);
               else begin
                  ew = wr_q.pop_front();
                  chk("wr_addr_data", {bus.mem_addr, bus.mem_wdata}, ew);
               end
            end
         end
         if (bus.mem_rd || bus.mem_wr) strobe_cnt++;
         if (bus.hld && !hld_prev) begin
            tenures++;
            chk("rereq_hlda_low", {47'h0, bus.hlda}, 48'h0);
         end
         if (done) done_cnt++;
         hld_prev = bus.hld;
      end
   end

   task automatic cfg(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic push_move(input logic [15:0] s, input logic [15:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         rd_q.push_back(s + 16'(i));
         wr_q.push_back({d + 16'(i), pat(s + 16'(i))});
      end
   endtask

   task automatic start_move(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input logic [15:0] c);
      cfg(2'd0, s); cfg(2'd1, d); cfg(2'd2, n); cfg(2'd3, c);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(nm, {47'h0, busy}, 48'h0);
   endtask

   initial begin
      int d0, s0, t0;
      int k;
      for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
      repeat (3) @(negedge clk);
      chk("reset_outputs", {bus.hld, bus.mem_rd, bus.mem_wr, busy, done, irq, err, 16'h0, bus.mem_addr},
          48'h0);
      rst_n = 1'b1;

      // 1: three-word move with interrupt
      d0 = done_cnt; s0 = strobe_cnt;
      push_move(16'h0010, 16'h0040, 3);
      start_move(16'h0010, 16'h0040, 16'd3, 16'h3);
      chk("t1_busy", {47'h0, busy}, 48'h1);
      wait_idle(200, "t1_timeout");
      @(negedge clk);
      chk("t1_strobes", 48'(strobe_cnt - s0), 48'd6);
      chk("t1_done", 48'(done_cnt - d0), 48'd1);
      chk("t1_irq", {47'h0, irq}, 48'h1);
      for (int i = 0; i < 3; i++) chk("t1_mem", {16'h0, mem[16'h40 + i]}, {16'h0, pat(16'h10 + 16'(i))});
      chk("t1_src_final", {32'h0, dut.src}, 48'h13);
      chk("t1_q_empty", 48'(rd_q.size() + wr_q.size()), 48'd0);

      // 2: twenty words in three tenures
      t0 = tenures; d0 = done_cnt;
      push_move(16'h0100, 16'h0200, 20);
      start_move(16'h0100, 16'h0200, 16'd20, 16'h3);
      wait_idle(400, "t2_timeout");
      @(negedge clk);
      chk("t2_tenures", 48'(tenures - t0), 48'd3);
      chk("t2_done", 48'(done_cnt - d0), 48'd1);
      chk("t2_q_empty", 48'(rd_q.size() + wr_q.size()), 48'd0);
      chk("t2_mem_first", {16'h0, mem[16'h200]}, {16'h0, pat(16'h100)});
      chk("t2_mem_last", {16'h0, mem[16'h213]}, {16'h0, pat(16'h113)});

      // 3: zero-length start
      cfg(2'd3, 16'h4);
      chk("t3_irq_cleared", {47'h0, irq}, 48'h0);
      t0 = tenures; s0 = strobe_cnt;
      cfg(2'd2, 16'd0);
      cfg(2'd3, 16'h3);
      chk("t3_done_pulse", {46'h0, done, busy}, 48'h2);
      chk("t3_irq", {47'h0, irq}, 48'h1);
      @(negedge clk);
      chk("t3_done_one_cycle", {47'h0, done}, 48'h0);
      repeat (5) @(negedge clk);
      chk("t3_no_bus", 48'((tenures - t0) + (strobe_cnt - s0)), 48'd0);

      // 4: source address wraps
      push_move(16'hFFFF, 16'h0300, 2);
      start_move(16'hFFFF, 16'h0300, 16'd2, 16'h3);
      wait_idle(200, "t4_timeout");
      @(negedge clk);
      chk("t4_q_empty", 48'(rd_q.size() + wr_q.size()), 48'd0);
      chk("t4_mem_wrap", {16'h0, mem[16'h301]}, {16'h0, pat(16'h0000)});
      chk("t4_src_final", {32'h0, dut.src}, 48'h0001);

      // 5: grant loss during the second write
      d0 = done_cnt;
      push_move(16'h0400, 16'h0500, 2);
      k = wr_cnt;
      start_move(16'h0400, 16'h0500, 16'd4, 16'h7);
      for (int i = 0; i < 100 && wr_cnt != k + 2; i++) begin
         @(posedge clk);
         #2;
      end
      chk("t5_second_wr_seen", 48'(wr_cnt - k), 48'd2);
      kill = 1'b1;
      wait_idle(50, "t5_timeout");
      @(negedge clk);
      chk("t5_err", {47'h0, err}, 48'h1);
      chk("t5_no_done", 48'(done_cnt - d0), 48'd0);
      chk("t5_irq", {47'h0, irq}, 48'h0);
      chk("t5_hld_low", {47'h0, bus.hld}, 48'h0);
      chk("t5_count_left", {32'h0, dut.count}, 48'd2);
      chk("t5_q_empty", 48'(rd_q.size() + wr_q.size()), 48'd0);
      kill = 1'b0;
      cfg(2'd3, 16'h4);
      chk("t5_err_cleared", {47'h0, err}, 48'h0);

      // 6: abort while waiting for the grant, then reset mid-read
      kill = 1'b1;
      d0 = done_cnt; s0 = strobe_cnt;
      start_move(16'h0600, 16'h0700, 16'd5, 16'h3);
      repeat (5) @(negedge clk);
      chk("t6_in_req", {46'h0, bus.hld, busy}, 48'h3);
      cfg(2'd3, 16'h8);
      wait_idle(20, "t6_timeout");
      @(negedge clk);
      chk("t6_abort_clean", {44'h0, done, irq, err, busy}, 48'h0);
      chk("t6_abort_no_done", 48'((done_cnt - d0) + (strobe_cnt - s0)), 48'd0);
      kill = 1'b0;
      sb_on = 1'b0;
      start_move(16'h0600, 16'h0700, 16'd4, 16'h3);
      for (int i = 0; i < 100 && !bus.mem_rd; i++) begin
         @(posedge clk);
         #2;
      end
      chk("t6_rd_seen", {47'h0, bus.mem_rd}, 48'h1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_reset", {bus.hld, bus.mem_rd, bus.mem_wr, busy, done, irq, err, 16'h0, bus.mem_addr}, 48'h0);
      chk("t6_reset_wdata", {16'h0, bus.mem_wdata}, 48'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
